// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV32I instruction encoder with valid/ready handshakes.
//
// Ports
//   i_clk, i_rst       clock; synchronous active-high reset (wins over i_en)
//   i_en               global advance enable; when low all state holds
//   i_valid / i_ready  request handshake (accept = i_valid & i_ready & i_en)
//   i_inst[63:0]       one-hot instruction ID (bit index table below)
//   i_rd/i_rs1/i_rs2   register fields; i_imm signed immediate / offset
//   o_valid / o_ready  result handshake (deliver = o_valid & o_ready & i_en)
//   o_word, o_err      encoded word; o_err marks an illegal request (word = NOP)
//   o_count            number of delivered words, wraps at 16 bits
//
// One-hot bit index of i_inst:
//    0 ADD   1 SUB   2 SLL   3 SLT   4 SLTU  5 XOR   6 SRL   7 SRA   8 OR    9 AND
//   10 ADDI 11 SLTI 12 SLTIU 13 XORI 14 ORI  15 ANDI 16 SLLI 17 SRLI 18 SRAI
//   19 LB   20 LH   21 LW   22 LBU  23 LHU  24 SB   25 SH   26 SW
//   27 BEQ  28 BNE  29 BLT  30 BGE  31 BLTU 32 BGEU 33 LUI  34 AUIPC 35 JAL 36 JALR
//   37 ECALL 38 EBREAK 39 CSRRW 40 CSRRS 41 CSRRC 42 CSRRWI 43 CSRRSI 44 CSRRCI
//   45 FENCE 46 FENCEI 47 UNKNOWN; bits 47..63 are illegal.
// Only N_param = 32 is supported.

module instr_encoder #(
  parameter int N_param = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [63:0]        i_inst,
  input  logic [4:0]         i_rd,
  input  logic [4:0]         i_rs1,
  input  logic [4:0]         i_rs2,
  input  logic [N_param-1:0] i_imm,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [N_param-1:0] o_word,
  output logic               o_err,
  output logic [15:0]        o_count
);

  typedef struct packed {
    logic [63:0] inst;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  typedef enum logic [3:0] {
    F_BAD, F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_ECALL, F_EBREAK, F_CSR, F_FENCE
  } fmt_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  // S1: raw request; S2: formatted word (drives outputs directly)
  req_t        r_s1;
  logic        r_s1_valid;
  logic        r_s2_valid;
  logic [31:0] r_word;
  logic        r_err;
  logic [15:0] r_count;

  logic        w_acc, w_dlv, w_s2_load;
  logic        w_onehot;
  logic [5:0]  w_idx;
  fmt_e        w_fmt;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm;
  logic        w_i12_ok, w_b13_ok, w_j21_ok;
  logic        w_err;
  logic [31:0] w_word;

  assign w_dlv     = r_s2_valid && o_ready && i_en;
  // S1 may move on when S2 is empty or is being drained this cycle
  assign w_s2_load = r_s1_valid && (!r_s2_valid || w_dlv);
  assign i_ready   = !i_rst && (!r_s1_valid || !r_s2_valid || w_dlv);
  assign w_acc     = i_valid && i_ready && i_en;

  assign o_valid = r_s2_valid;
  assign o_word  = r_word;
  assign o_err   = r_err;
  assign o_count = r_count;

  // ---------------- S1 classification ----------------
  assign w_onehot = $onehot(r_s1.inst);

  always_comb begin
    w_idx = '0;
    for (int k = 0; k < 64; k++)
      if (r_s1.inst[k]) w_idx = 6'(k);
  end

  always_comb begin
    w_fmt = F_BAD;
    w_opc = '0;
    w_f3  = '0;
    w_f7  = '0;
    if (w_onehot) begin
      case (w_idx)
        6'd0:  begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd0; end
        6'd1:  begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd0; w_f7 = F7_ALT; end
        6'd2:  begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd1; end
        6'd3:  begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd2; end
        6'd4:  begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd3; end
        6'd5:  begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd4; end
        6'd6:  begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd5; end
        6'd7:  begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd5; w_f7 = F7_ALT; end
        6'd8:  begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd6; end
        6'd9:  begin w_fmt = F_R;  w_opc = OPC_OP; w_f3 = 3'd7; end
        6'd10: begin w_fmt = F_I;  w_opc = OPC_OPIMM; w_f3 = 3'd0; end
        6'd11: begin w_fmt = F_I;  w_opc = OPC_OPIMM; w_f3 = 3'd2; end
        6'd12: begin w_fmt = F_I;  w_opc = OPC_OPIMM; w_f3 = 3'd3; end
        6'd13: begin w_fmt = F_I;  w_opc = OPC_OPIMM; w_f3 = 3'd4; end
        6'd14: begin w_fmt = F_I;  w_opc = OPC_OPIMM; w_f3 = 3'd6; end
        6'd15: begin w_fmt = F_I;  w_opc = OPC_OPIMM; w_f3 = 3'd7; end
        6'd16: begin w_fmt = F_SH; w_opc = OPC_OPIMM; w_f3 = 3'd1; end
        6'd17: begin w_fmt = F_SH; w_opc = OPC_OPIMM; w_f3 = 3'd5; end
        6'd18: begin w_fmt = F_SH; w_opc = OPC_OPIMM; w_f3 = 3'd5; w_f7 = F7_ALT; end
        6'd19: begin w_fmt = F_I;  w_opc = OPC_LOAD; w_f3 = 3'd0; end
        6'd20: begin w_fmt = F_I;  w_opc = OPC_LOAD; w_f3 = 3'd1; end
        6'd21: begin w_fmt = F_I;  w_opc = OPC_LOAD; w_f3 = 3'd2; end
        6'd22: begin w_fmt = F_I;  w_opc = OPC_LOAD; w_f3 = 3'd4; end
        6'd23: begin w_fmt = F_I;  w_opc = OPC_LOAD; w_f3 = 3'd5; end
        6'd24: begin w_fmt = F_S;  w_opc = OPC_STORE; w_f3 = 3'd0; end
        6'd25: begin w_fmt = F_S;  w_opc = OPC_STORE; w_f3 = 3'd1; end
        6'd26: begin w_fmt = F_S;  w_opc = OPC_STORE; w_f3 = 3'd2; end
        6'd27: begin w_fmt = F_B;  w_opc = OPC_BRANCH; w_f3 = 3'd0; end
        6'd28: begin w_fmt = F_B;  w_opc = OPC_BRANCH; w_f3 = 3'd1; end
        6'd29: begin w_fmt = F_B;  w_opc = OPC_BRANCH; w_f3 = 3'd4; end
        6'd30: begin w_fmt = F_B;  w_opc = OPC_BRANCH; w_f3 = 3'd5; end
        6'd31: begin w_fmt = F_B;  w_opc = OPC_BRANCH; w_f3 = 3'd6; end
        6'd32: begin w_fmt = F_B;  w_opc = OPC_BRANCH; w_f3 = 3'd7; end
        6'd33: begin w_fmt = F_U;  w_opc = OPC_LUI; end
        6'd34: begin w_fmt = F_U;  w_opc = OPC_AUIPC; end
        6'd35: begin w_fmt = F_J;  w_opc = OPC_JAL; end
        6'd36: begin w_fmt = F_I;  w_opc = OPC_JALR; w_f3 = 3'd0; end
        6'd37: w_fmt = F_ECALL;
        6'd38: w_fmt = F_EBREAK;
        6'd39: begin w_fmt = F_CSR; w_opc = OPC_SYSTEM; w_f3 = 3'd1; end
        6'd40: begin w_fmt = F_CSR; w_opc = OPC_SYSTEM; w_f3 = 3'd2; end
        6'd41: begin w_fmt = F_CSR; w_opc = OPC_SYSTEM; w_f3 = 3'd3; end
        6'd42: begin w_fmt = F_CSR; w_opc = OPC_SYSTEM; w_f3 = 3'd5; end
        6'd43: begin w_fmt = F_CSR; w_opc = OPC_SYSTEM; w_f3 = 3'd6; end
        6'd44: begin w_fmt = F_CSR; w_opc = OPC_SYSTEM; w_f3 = 3'd7; end
        6'd45: begin w_fmt = F_FENCE; w_opc = OPC_FENCE; w_f3 = 3'd0; end
        6'd46: begin w_fmt = F_FENCE; w_opc = OPC_FENCE; w_f3 = 3'd1; end
        default: w_fmt = F_BAD;   // UNKNOWN and unassigned bits
      endcase
    end
  end

  // ---------------- formatting ----------------
  assign w_imm = r_s1.imm;
  // sign-range checks: all bits above the field's sign bit must match it
  assign w_i12_ok = (&w_imm[31:11]) | ~(|w_imm[31:11]);
  assign w_b13_ok = (&w_imm[31:12]) | ~(|w_imm[31:12]);
  assign w_j21_ok = (&w_imm[31:20]) | ~(|w_imm[31:20]);

  always_comb begin
    w_err  = 1'b0;
    w_word = '0;
    case (w_fmt)
      F_R:  w_word = {w_f7, r_s1.rs2, r_s1.rs1, w_f3, r_s1.rd, w_opc};
      F_I: begin
        w_err  = !w_i12_ok;
        w_word = {w_imm[11:0], r_s1.rs1, w_f3, r_s1.rd, w_opc};
      end
      F_SH: begin
        w_err  = |w_imm[31:5];
        w_word = {w_f7, w_imm[4:0], r_s1.rs1, w_f3, r_s1.rd, w_opc};
      end
      F_S: begin
        w_err  = !w_i12_ok;
        w_word = {w_imm[11:5], r_s1.rs2, r_s1.rs1, w_f3, w_imm[4:0], w_opc};
      end
      F_B: begin
        w_err  = w_imm[0] | !w_b13_ok;
        w_word = {w_imm[12], w_imm[10:5], r_s1.rs2, r_s1.rs1, w_f3,
                  w_imm[4:1], w_imm[11], w_opc};
      end
      F_U: begin
        w_err  = |w_imm[11:0];
        w_word = {w_imm[31:12], r_s1.rd, w_opc};
      end
      F_J: begin
        w_err  = w_imm[0] | !w_j21_ok;
        w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], r_s1.rd, w_opc};
      end
      F_ECALL:  w_word = 32'h0000_0073;
      F_EBREAK: w_word = 32'h0010_0073;
      F_CSR: begin
        // CSR address is unsigned; *I forms reuse the rs1 slot as uimm
        w_err  = |w_imm[31:12];
        w_word = {w_imm[11:0], r_s1.rs1, w_f3, r_s1.rd, w_opc};
      end
      F_FENCE:  w_word = {w_imm[11:0], r_s1.rs1, w_f3, r_s1.rd, w_opc};
      default:  w_err  = 1'b1;
    endcase
    if (w_err) w_word = NOP;
  end

  // ---------------- pipeline state ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_word     <= '0;
      r_err      <= 1'b0;
      r_count    <= '0;
      r_s1       <= '0;
    end else if (i_en) begin
      if (w_dlv) r_count <= r_count + 16'd1;

      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_word     <= w_word;
        r_err      <= w_err;
      end else if (w_dlv) begin
        r_s2_valid <= 1'b0;
      end

      if (w_acc) begin
        r_s1_valid <= 1'b1;
        r_s1       <= '{inst: i_inst, rd: i_rd, rs1: i_rs1, rs2: i_rs2, imm: i_imm};
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  logic        i_clk = 1'b0;
  logic        i_rst, i_en, i_valid, i_ready;
  logic [63:0] i_inst;
  logic [4:0]  i_rd, i_rs1, i_rs2;
  logic [31:0] i_imm;
  logic        o_valid, o_ready, o_err;
  logic [31:0] o_word;
  logic [15:0] o_count;

  instr_encoder #(.N_param(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid), .i_ready(i_ready),
    .i_inst(i_inst), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
    .o_valid(o_valid), .o_ready(o_ready), .o_word(o_word), .o_err(o_err),
    .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  // reference model: in-flight requests in order, each with the number of
  // enabled edges since acceptance; the oldest is visible once it is 2 old
  typedef struct {
    logic [32:0] exp;
    int          age;
  } ent_t;
  ent_t        q[$];
  logic [32:0] got[$];
  int          mcount = 0;
  int          n_cmp = 0, n_bad = 0;

  int F3[47] = '{0,0,1,2,3,4,5,5,6,7, 0,2,3,4,6,7, 1,5,5, 0,1,2,4,5, 0,1,2,
                 0,1,4,5,6,7, 0,0,0,0,0,0, 1,2,3,5,6,7, 0,1};
  int IMMS[18] = '{0, 5, -2048, 2047, 2048, -2049, -4096, 4094, 4095, -4098,
                   1048574, -1048576, 1048576, 31, 32, 4096, 32'h12345000, 3};

  function automatic logic [63:0] oh(int id);
    logic [63:0] one;
    one = 64'd1;
    return one << id;
  endfunction

  function automatic logic [32:0] ref_enc(logic [63:0] inst, logic [31:0] rd,
                                          logic [31:0] rs1, logic [31:0] rs2,
                                          logic [31:0] imm);
    int id, ones, s;
    logic [31:0] f3, w;
    bit err;
    id = -1; ones = 0; err = 0; w = 0;
    for (int k = 0; k < 64; k++) if (inst[k]) begin ones++; id = k; end
    if (ones != 1 || id > 46) return {1'b1, 32'h13};
    s  = $signed(imm);
    f3 = F3[id];
    if (id <= 9)
      w = ((id == 1 || id == 7) ? 32'h4000_0000 : 32'h0) | rs2 << 20 | rs1 << 15
          | f3 << 12 | rd << 7 | 32'h33;
    else if (id <= 15 || (id >= 19 && id <= 23) || id == 36) begin
      err = s < -2048 || s > 2047;
      w = (imm & 32'hFFF) << 20 | rs1 << 15 | f3 << 12 | rd << 7
          | (id <= 15 ? 32'h13 : (id == 36 ? 32'h67 : 32'h03));
    end else if (id <= 18) begin
      err = s < 0 || s > 31;
      w = (id == 18 ? 32'h4000_0000 : 32'h0) | (imm & 31) << 20 | rs1 << 15
          | f3 << 12 | rd << 7 | 32'h13;
    end else if (id <= 26) begin
      err = s < -2048 || s > 2047;
      w = ((imm >> 5) & 127) << 25 | rs2 << 20 | rs1 << 15 | f3 << 12
          | (imm & 31) << 7 | 32'h23;
    end else if (id <= 32) begin
      err = (s % 2 != 0) || s < -4096 || s > 4094;
      w = ((imm >> 12) & 1) << 31 | ((imm >> 5) & 63) << 25 | rs2 << 20 | rs1 << 15
          | f3 << 12 | ((imm >> 1) & 15) << 8 | ((imm >> 11) & 1) << 7 | 32'h63;
    end else if (id <= 34) begin
      err = (imm & 32'hFFF) != 0;
      w = (imm & 32'hFFFF_F000) | rd << 7 | (id == 33 ? 32'h37 : 32'h17);
    end else if (id == 35) begin
      err = (s % 2 != 0) || s < -1048576 || s > 1048574;
      w = ((imm >> 20) & 1) << 31 | ((imm >> 1) & 1023) << 21 | ((imm >> 11) & 1) << 20
          | ((imm >> 12) & 255) << 12 | rd << 7 | 32'h6F;
    end else if (id == 37) w = 32'h73;
    else if (id == 38) w = 32'h0010_0073;
    else if (id <= 44) begin
      err = s < 0 || s > 4095;
      w = (imm & 32'hFFF) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | 32'h73;
    end else
      w = (imm & 32'hFFF) << 20 | rs1 << 15 | f3 << 12 | rd << 7 | 32'h0F;
    return err ? {1'b1, 32'h13} : {1'b0, w};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic v, logic [63:0] inst, logic [4:0] rd, logic [4:0] rs1,
                       logic [4:0] rs2, logic [31:0] imm);
    i_valid = v; i_inst = inst; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
  endtask

  // one clock: check at negedge, advance the model at posedge
  task automatic cycle();
    logic exp_v, exp_rdy, acc, dlv, rst_e;
    @(negedge i_clk);
    exp_v   = q.size() > 0 && q[0].age >= 2;
    exp_rdy = !i_rst && (q.size() < 2 || (exp_v && o_ready && i_en));
    chk("i_ready", 64'(i_ready), 64'(exp_rdy));
    chk("o_valid", 64'(o_valid), 64'(exp_v));
    chk("o_count", 64'(o_count), 64'(mcount));
    if (exp_v) chk("o_err_word", 64'({o_err, o_word}), 64'(q[0].exp));
    acc   = i_valid && exp_rdy && i_en;
    dlv   = exp_v && o_ready && i_en;
    rst_e = i_rst;
    @(posedge i_clk);
    if (rst_e) begin
      q.delete();
      mcount = 0;
    end else if (i_en) begin
      if (dlv) begin
        got.push_back(q[0].exp);
        void'(q.pop_front());
        mcount = (mcount + 1) % 65536;
      end
      foreach (q[k]) q[k].age++;
      if (acc) q.push_back('{exp: ref_enc(i_inst, 32'(i_rd), 32'(i_rs1), 32'(i_rs2), i_imm),
                             age: 1});
    end
    #1;
    if (rst_e) begin
      chk("rst_o_word", 64'(o_word), 64'h0);
      chk("rst_o_err", 64'(o_err), 64'h0);
      chk("rst_o_valid", 64'(o_valid), 64'h0);
      chk("rst_o_count", 64'(o_count), 64'h0);
    end
  endtask

  initial begin
    int r, id, guard;
    logic [63:0] inst;
    i_rst = 1; i_en = 1; o_ready = 1;
    drive(0, 64'h0, 0, 0, 0, 0);
    @(posedge i_clk); #1;
    cycle();                      // second reset edge, checks reset outputs
    i_rst = 0;

    // three back-to-back requests
    got.delete();
    drive(1, oh(10), 1, 0, 0, 5);   cycle();
    drive(1, oh(0), 3, 1, 2, 0);    cycle();
    drive(1, oh(26), 0, 1, 2, 8);   cycle();
    drive(0, 64'h0, 0, 0, 0, 0);
    repeat (4) cycle();
    chk("b2b_n", 64'(got.size()), 64'd3);
    chk("b2b_0", 64'(got[0]), {31'd0, 1'b0, 32'h0050_0093});
    chk("b2b_1", 64'(got[1]), {31'd0, 1'b0, 32'h0020_81B3});
    chk("b2b_2", 64'(got[2]), {31'd0, 1'b0, 32'h0020_A423});
    chk("b2b_cnt", 64'(o_count), 64'd3);

    // JAL / LUI / EBREAK
    got.delete();
    drive(1, oh(35), 1, 0, 0, 8);            cycle();
    drive(1, oh(33), 5, 0, 0, 32'h12345000); cycle();
    drive(1, oh(38), 0, 0, 0, 0);            cycle();
    drive(0, 64'h0, 0, 0, 0, 0);
    repeat (4) cycle();
    chk("ju_0", 64'(got[0]), {31'd0, 1'b0, 32'h0080_00EF});
    chk("ju_1", 64'(got[1]), {31'd0, 1'b0, 32'h1234_52B7});
    chk("ju_2", 64'(got[2]), {31'd0, 1'b0, 32'h0010_0073});

    // illegal immediates followed by a legal request
    got.delete();
    drive(1, oh(27), 0, 1, 2, 3);    cycle();
    drive(1, oh(10), 1, 0, 0, 2048); cycle();
    drive(1, oh(10), 1, 0, 0, 5);    cycle();
    drive(0, 64'h0, 0, 0, 0, 0);
    repeat (4) cycle();
    chk("err_0", 64'(got[0]), {31'd0, 1'b1, 32'h0000_0013});
    chk("err_1", 64'(got[1]), {31'd0, 1'b1, 32'h0000_0013});
    chk("err_2", 64'(got[2]), {31'd0, 1'b0, 32'h0050_0093});

    // backpressure: only two requests fit
    got.delete();
    o_ready = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1, oh(10), 5'(k + 1), 0, 0, 32'(k)); cycle();
    end
    chk("bp_rdy_low", 64'(i_ready), 64'h0);
    o_ready = 1;
    drive(0, 64'h0, 0, 0, 0, 0);
    repeat (5) cycle();
    chk("bp_n", 64'(got.size()), 64'd2);

    // reset with both stages full
    got.delete();
    o_ready = 0;
    repeat (3) begin drive(1, oh(0), 7, 7, 7, 0); cycle(); end
    i_rst = 1; cycle();
    i_rst = 0; o_ready = 1;
    drive(0, 64'h0, 0, 0, 0, 0);
    repeat (4) cycle();
    chk("rst_no_stale", 64'(got.size()), 64'd0);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 99);
      id = $urandom_range(0, 46);
      if (r < 85)      inst = oh(id);
      else if (r < 90) inst = oh(47);
      else if (r < 95) inst = {$urandom, $urandom};
      else             inst = oh($urandom_range(48, 63));
      drive($urandom_range(0, 3) != 0, inst, 5'($urandom), 5'($urandom), 5'($urandom),
            ($urandom_range(0, 1) != 0) ? 32'(IMMS[$urandom_range(0, 17)]) :
            (($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : 32'($urandom)));
      o_ready = $urandom_range(0, 3) != 0;
      i_en    = $urandom_range(0, 9) != 0;
      i_rst   = $urandom_range(0, 199) == 0;
      cycle();
    end
    i_rst = 0; i_en = 1;

    // o_count wrap
    i_rst = 1; cycle(); i_rst = 0;
    o_ready = 1;
    drive(1, oh(10), 1, 0, 0, 5);
    guard = 0;
    while (mcount != 65535 && guard < 70000) begin cycle(); guard++; end
    chk("cnt_ffff", 64'(o_count), 64'hFFFF);
    cycle();
    chk("cnt_wrap", 64'(o_count), 64'h0);
    drive(0, 64'h0, 0, 0, 0, 0);
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
